// File: rtl/wordcount_pkg.sv
// Shared types for the word-count command dispatcher: FSM states,
// command codes and the queued-command record.
package wordcount_pkg;

    typedef enum logic [1:0] {
        WAIT_READY,
        IDLE,
        LAUNCH,
        RUN
    } state_t;

    localparam logic [31:0] CMD_SEARCH_ADD  = 32'd1;
    localparam logic [31:0] CMD_RESULT_COPY = 32'd2;
    localparam logic [31:0] CMD_CLEAR       = 32'd3;

    typedef struct packed {
        logic [31:0] command;
        logic [31:0] words;
        logic [63:0] offset;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // A code selects an engine only when it falls in 1..num_eng.
    function automatic logic cmd_valid(input logic [31:0] code, input int num_eng);
        return (code != 32'd0) && (code <= 32'(num_eng));
    endfunction

endpackage

// File: rtl/wordcount_cmd_dispatch_if.sv
// Command, engine and accumulator signals of the dispatcher.
// slave = dispatcher view, master = host/engine side.
interface wordcount_cmd_dispatch_if #(
    parameter int NUM_ENG = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
);
    logic                             ready_in;
    logic                             kick;
    logic [31:0]                      command;
    logic [31:0]                      num_of_words;
    logic [63:0]                      global_memory_offset;
    logic                             busy;
    logic [NUM_ENG-1:0]               eng_kick;
    logic [NUM_ENG-1:0]               eng_busy;
    logic [31:0]                      eng_words;
    logic [63:0]                      eng_offset;
    logic [NUM_ENG-1:0][ADDR_W-1:0]   eng_addr;
    logic [NUM_ENG-1:0][DATA_W-1:0]   eng_din;
    logic [NUM_ENG-1:0]               eng_we;
    logic [ADDR_W-1:0]                accum_addr;
    logic [DATA_W-1:0]                accum_din;
    logic                             accum_we;
    logic                             err_clear;
    logic                             err_unknown;
    logic                             err_overflow;
    logic                             err_timeout;
    logic [15:0]                      done_count;

    modport slave (
        input  ready_in, kick, command, num_of_words, global_memory_offset,
               eng_busy, eng_addr, eng_din, eng_we, err_clear,
        output busy, eng_kick, eng_words, eng_offset,
               accum_addr, accum_din, accum_we,
               err_unknown, err_overflow, err_timeout, done_count
    );

    modport master (
        output ready_in, kick, command, num_of_words, global_memory_offset,
               eng_busy, eng_addr, eng_din, eng_we, err_clear,
        input  busy, eng_kick, eng_words, eng_offset,
               accum_addr, accum_din, accum_we,
               err_unknown, err_overflow, err_timeout, done_count
    );
endinterface

// File: rtl/cmd_fifo.sv
// Small power-of-two FIFO with first-word-fall-through read port.
// The caller guards push against full (allowing push while full only when
// popping the same cycle) and pop against empty.
module cmd_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

    // Pointers and occupancy; pointers wrap naturally on power-of-two depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/wordcount_cmd_dispatch.sv
// Queues host commands and launches them one at a time on the selected
// engine, muxing that engine's accumulator port while it runs.
module wordcount_cmd_dispatch
    import wordcount_pkg::*;
#(
    parameter int NUM_ENG = 3,
    parameter int QDEPTH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    reset_n,
    wordcount_cmd_dispatch_if.slave bus
);
    localparam int          SEL_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam logic [31:0] TMO   = 32'(TIMEOUT);

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [NUM_ENG-1:0] eng_kick_q;
    logic [31:0]        words_q;
    logic [63:0]        offset_q;
    logic [31:0]        run_cnt;
    logic [15:0]        done_q;
    logic               err_unk_q, err_ovf_q, err_tmo_q;

    cmd_t               push_cmd, head;
    logic               full, empty, push, pop, cmd_ok;
    logic               ovf_set, unk_set, tmo_set, run_done;

    assign push_cmd = {bus.command, bus.num_of_words, bus.global_memory_offset};

    // A full queue still takes a kick when the head leaves the same cycle.
    assign pop      = (state == IDLE) && !empty;
    assign push     = bus.kick && (!full || pop);
    assign ovf_set  = bus.kick && full && !pop;
    assign cmd_ok   = cmd_valid(head.command, NUM_ENG);
    assign unk_set  = pop && !cmd_ok;
    // eng_kick still high means the engine has not had a chance to raise busy.
    assign run_done = (state == RUN) && (eng_kick_q == '0) && !bus.eng_busy[sel];
    assign tmo_set  = (state == RUN) && (TMO != 32'd0) && (run_cnt == TMO - 32'd1);

    cmd_fifo #(.WIDTH(CMD_W), .DEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (push_cmd),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    // Dispatch FSM: pop, latch parameters, pulse one engine, wait for it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_READY;
            sel        <= '0;
            eng_kick_q <= '0;
            words_q    <= '0;
            offset_q   <= '0;
            run_cnt    <= '0;
            done_q     <= '0;
        end else begin
            eng_kick_q <= '0;
            case (state)
                WAIT_READY: if (bus.ready_in) state <= IDLE;
                IDLE: begin
                    if (pop && cmd_ok) begin
                        sel      <= SEL_W'(head.command - 32'd1);
                        words_q  <= head.words;
                        offset_q <= head.offset;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    eng_kick_q <= NUM_ENG'(1) << sel;
                    run_cnt    <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    // Saturates at TMO so the timeout flag fires only once.
                    if (run_cnt != TMO) run_cnt <= run_cnt + 32'd1;
                    if (run_done) begin
                        done_q <= done_q + 16'd1;
                        state  <= IDLE;
                    end
                end
                default: state <= WAIT_READY;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as err_clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_unk_q <= 1'b0;
            err_ovf_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            err_unk_q <= unk_set || (err_unk_q && !bus.err_clear);
            err_ovf_q <= ovf_set || (err_ovf_q && !bus.err_clear);
            err_tmo_q <= tmo_set || (err_tmo_q && !bus.err_clear);
        end
    end

    // Accumulator port follows the selected engine only while it owns it.
    always_comb begin
        bus.accum_we   = 1'b0;
        bus.accum_addr = '0;
        bus.accum_din  = '0;
        if (state == LAUNCH || state == RUN) begin
            bus.accum_we   = bus.eng_we[sel];
            bus.accum_addr = bus.eng_addr[sel];
            bus.accum_din  = bus.eng_din[sel];
        end
    end

    assign bus.busy         = !bus.ready_in || !empty || (state != IDLE);
    assign bus.eng_kick     = eng_kick_q;
    assign bus.eng_words    = words_q;
    assign bus.eng_offset   = offset_q;
    assign bus.err_unknown  = err_unk_q;
    assign bus.err_overflow = err_ovf_q;
    assign bus.err_timeout  = err_tmo_q;
    assign bus.done_count   = done_q;
endmodule
